// File: rtl/lut_pkg.sv
// Shared types and defaults for the replicated coefficient LUT bank.
package lut_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DEPTH  = 3392;
  localparam int DEF_N_DIR  = 4;
  localparam int DEF_N_RD   = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } lut_st_e;

  // Flattened lane index of read port p in direction group d.
  function automatic int lane(input int d, input int p, input int n_rd = DEF_N_RD);
    return d * n_rd + p;
  endfunction

endpackage

// File: rtl/lut_dp_ram.sv
// Dual-port table RAM, synchronous read/write, 1-cycle read latency.
module lut_dp_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 3392
) (
  input  logic              clk,
  input  logic              en_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              en_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic [DATA_W-1:0] rdata_b
);

`ifdef LUT_BANK_FOUNDRY_SRAM
  fdry_sram_dp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_macro (
    .clk(clk),
    .cen_a(en_a), .wen_a(we_a), .a_a(addr_a), .d_a(wdata_a), .q_a(rdata_a),
    .cen_b(en_b), .wen_b(we_b), .a_b(addr_b), .d_b(wdata_b), .q_b(rdata_b)
  );
`else
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read data only moves on a read, so it holds across write traffic.
  always_ff @(posedge clk) begin
    if (en_a) begin
      if (we_a) mem[addr_a] <= wdata_a;
      else      rdata_a <= ({1'b0, addr_a} < LIM) ? mem[addr_a] : '0;
    end
    if (en_b) begin
      if (we_b) mem[addr_b] <= wdata_b;
      else      rdata_b <= ({1'b0, addr_b} < LIM) ? mem[addr_b] : '0;
    end
  end
`endif

endmodule

// File: rtl/lut_bank.sv
// Coefficient table replicated over N_DIR direction groups with N_RD
// lookup lanes each; streamed two words per beat, 2-cycle lookups.
module lut_bank
  import lut_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int N_DIR  = DEF_N_DIR,
  parameter int N_RD   = DEF_N_RD
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load_start,
  input  logic                           ld_valid,
  output logic                           ld_ready,
  input  logic [DATA_W-1:0]              ld_data0,
  input  logic [DATA_W-1:0]              ld_data1,
  output logic                           lut_loaded,
  input  logic                           lk_valid,
  output logic                           lk_ready,
  input  logic [N_DIR*N_RD*ADDR_W-1:0]   lk_addr,
  output logic                           lk_rvalid,
  output logic [N_DIR*N_RD*DATA_W-1:0]   lk_rdata,
  output logic                           lk_err
);

  localparam int              NL   = N_DIR * N_RD;
  localparam int              LAT  = 2;
  localparam logic [ADDR_W:0]   LIM  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 2);
  localparam logic [ADDR_W-1:0] TWO  = ADDR_W'(2);

  lut_st_e           st;
  logic [ADDR_W-1:0] wcnt;
  logic              wr_pend;
  logic [DATA_W-1:0] wr_d0, wr_d1;
  logic              ld_acc, final_wr;
  logic [ADDR_W-1:0] nxt_addr;

  assign ld_acc   = ld_valid & ld_ready & ~load_start;
  assign final_wr = wr_pend && (wcnt == LAST);
  // Address the beat accepted this cycle will land on.
  assign nxt_addr = wr_pend ? wcnt + TWO : wcnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st         <= IDLE;
      wcnt       <= '0;
      wr_pend    <= 1'b0;
      wr_d0      <= '0;
      wr_d1      <= '0;
      ld_ready   <= 1'b0;
      lut_loaded <= 1'b0;
    end else begin
      wr_pend <= ld_acc;
      if (ld_acc) begin
        wr_d0 <= ld_data0;
        wr_d1 <= ld_data1;
      end
      case (st)
        IDLE, DONE: begin
          if (load_start) begin
            st         <= LOAD;
            wcnt       <= '0;
            ld_ready   <= 1'b1;
            lut_loaded <= 1'b0;
          end
        end
        LOAD: begin
          if (load_start) begin
            wcnt     <= '0;
            ld_ready <= 1'b1;
          end else begin
            if (wr_pend) wcnt <= wcnt + TWO;
            // Close the stream once the last beat is in hand.
            if (ld_acc && nxt_addr == LAST) ld_ready <= 1'b0;
            if (final_wr) begin
              st         <= DONE;
              lut_loaded <= 1'b1;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign lk_ready = lut_loaded;

  logic                          lk_acc;
  logic [LAT-1:0]                vld_pipe;
  logic [NL-1:0][ADDR_W-1:0]     addr_v, s1_addr;
  logic [NL-1:0]                 oor_v, s1_oor, rd_ok;
  logic [NL-1:0][DATA_W-1:0]     q, rdata_v;
  logic                          ram_en;
  logic [ADDR_W-1:0]             wcnt_odd;

  assign lk_acc   = lk_valid & lut_loaded;
  assign addr_v   = lk_addr;
  assign ram_en   = wr_pend | vld_pipe[0];
  assign wcnt_odd = {wcnt[ADDR_W-1:1], 1'b1};

  always_comb begin
    oor_v = '0;
    for (int i = 0; i < NL; i++) oor_v[i] = ({1'b0, addr_v[i]} >= LIM);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      s1_addr  <= '0;
      s1_oor   <= '0;
      rd_ok    <= '0;
      lk_err   <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[LAT-2:0], lk_acc};
      if (lk_acc) begin
        s1_addr <= addr_v;
        s1_oor  <= oor_v;
      end
      // rd_ok gates the raw RAM outputs: zero after reset and on bad lanes.
      if (vld_pipe[0]) rd_ok <= ~s1_oor;
      lk_err <= vld_pipe[0] & (|s1_oor);
    end
  end

  assign lk_rvalid = vld_pipe[LAT-1];

  for (genvar d = 0; d < N_DIR; d++) begin : g_dir
    for (genvar k = 0; k < N_RD / 2; k++) begin : g_pair
      localparam int LA = lane(d, 2 * k, N_RD);
      localparam int LB = LA + 1;
      lut_dp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ram (
        .clk    (clk),
        .en_a   (ram_en),
        .we_a   (wr_pend),
        .addr_a (wr_pend ? wcnt : s1_addr[LA]),
        .wdata_a(wr_d0),
        .rdata_a(q[LA]),
        .en_b   (ram_en),
        .we_b   (wr_pend),
        .addr_b (wr_pend ? wcnt_odd : s1_addr[LB]),
        .wdata_b(wr_d1),
        .rdata_b(q[LB])
      );
    end
  end

  for (genvar i = 0; i < NL; i++) begin : g_lane
    assign rdata_v[i] = rd_ok[i] ? q[i] : '0;
  end
  assign lk_rdata = rdata_v;

endmodule

// File: tb/tb_lut_bank.sv
// Directed bench for lut_bank: vector table plus load/restart/reset sequences.
module tb_lut_bank;
  import lut_pkg::*;

  localparam int DW = 32, AW = 12, DEPTH = 3392, ND = 4, NR = 4;
  localparam int NL = ND * NR, HALF = DEPTH / 2;

  logic clk = 1'b0, rst = 1'b0;
  logic load_start = 1'b0, ld_valid = 1'b0, ld_ready, lut_loaded;
  logic [DW-1:0] ld_data0 = '0, ld_data1 = '0;
  logic lk_valid = 1'b0, lk_ready, lk_rvalid, lk_err;
  logic [NL*AW-1:0] lk_addr = '0;
  logic [NL*DW-1:0] lk_rdata;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  lut_bank #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .N_DIR(ND), .N_RD(NR)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_data0(ld_data0), .ld_data1(ld_data1),
    .lut_loaded(lut_loaded), .lk_valid(lk_valid), .lk_ready(lk_ready),
    .lk_addr(lk_addr), .lk_rvalid(lk_rvalid), .lk_rdata(lk_rdata), .lk_err(lk_err)
  );

  typedef logic [NL-1:0][AW-1:0] req_t;
  typedef struct {
    int base;
    int step;
    int bad_lane;
    int bad_addr;
    bit exp_err;
  } vec_t;

  vec_t tbl [7];
  req_t breq [256];
  bit   berr [256];
  int   bn;
  bit   binv;

  task automatic chk(input string name, input logic [NL*DW-1:0] got, input logic [NL*DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model(input int a, input bit inv);
    logic [DW-1:0] v;
    v = DW'(a);
    return inv ? ~v : v;
  endfunction

  // Issues breq[0..bn-1] back to back and checks each result 2 cycles later.
  task automatic burst(input string tag);
    for (int t = 0; t <= bn + 2; t++) begin
      if (t >= 2 && t - 2 < bn) begin
        int j;
        int a;
        logic [NL-1:0][DW-1:0] e;
        j = t - 2;
        for (int l = 0; l < NL; l++) begin
          a = int'(breq[j][l]);
          e[l] = (a >= DEPTH) ? '0 : model(a, binv);
        end
        chk($sformatf("%s[%0d] rvalid", tag, j), lk_rvalid, 1);
        chk($sformatf("%s[%0d] rdata", tag, j), lk_rdata, e);
        chk($sformatf("%s[%0d] err", tag, j), lk_err, berr[j]);
      end else begin
        chk($sformatf("%s t%0d idle rvalid", tag, t), lk_rvalid, 0);
      end
      if (t < bn) begin
        lk_valid = 1'b1;
        lk_addr  = breq[t];
      end else begin
        lk_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  // Start pulse carries a junk beat, which must be discarded if in LOAD.
  task automatic load_table(input bit inv, input bit gaps, input int nb);
    int b, cyc;
    bit v, acc;
    b = 0;
    cyc = 0;
    load_start = 1'b1;
    ld_valid   = 1'b1;
    ld_data0   = 32'hdead_beef;
    ld_data1   = 32'hbad0_cafe;
    @(negedge clk);
    load_start = 1'b0;
    while (b < nb && cyc < 10000) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      ld_valid = v;
      ld_data0 = model(2 * b, inv);
      ld_data1 = model(2 * b + 1, inv);
      if (nb < HALF) begin
        lk_valid = 1'b1;
        lk_addr  = '0;
        chk("lookup_unloaded", {lk_rvalid, lk_ready}, 0);
      end
      acc = v && ld_ready;
      @(negedge clk);
      if (acc) b++;
      cyc++;
    end
    ld_valid = 1'b0;
    lk_valid = 1'b0;
    chk("load_beats_accepted", b, nb);
    if (nb == HALF) begin
      chk("ld_ready_after_last", ld_ready, 0);
      chk("loaded_not_yet", lut_loaded, 0);
      @(negedge clk);
      chk("loaded_after_write", lut_loaded, 1);
      chk("lk_ready_loaded", lk_ready, 1);
    end
  endtask

  task automatic run_table(input bit inv);
    for (int i = 0; i < 7; i++) begin
      for (int l = 0; l < NL; l++)
        breq[0][l] = (l == tbl[i].bad_lane) ? AW'(tbl[i].bad_addr)
                                             : AW'((tbl[i].base + tbl[i].step * l) % DEPTH);
      berr[0] = tbl[i].exp_err;
      bn   = 1;
      binv = inv;
      burst($sformatf("vec%0d", i));
    end
  endtask

  task automatic sweep(input bit inv);
    bn   = DEPTH / NL;
    binv = inv;
    for (int j = 0; j < bn; j++) begin
      for (int l = 0; l < NL; l++) breq[j][l] = AW'(j * NL + l);
      berr[j] = 1'b0;
    end
    burst(inv ? "sweep_inv" : "sweep");
  endtask

  initial begin
    tbl[0] = '{0,    0,   -1, 0,    1'b0};
    tbl[1] = '{1,    0,   -1, 0,    1'b0};
    tbl[2] = '{3391, 0,   -1, 0,    1'b0};
    tbl[3] = '{100,  7,   -1, 0,    1'b0};
    tbl[4] = '{3390, 1,   -1, 0,    1'b0};
    tbl[5] = '{10,   3,    5, 3392, 1'b1};
    tbl[6] = '{0,    200,  0, 4095, 1'b1};

    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_lut_loaded", lut_loaded, 0);
    chk("rst_lk_ready", lk_ready, 0);
    chk("rst_lk_rvalid", lk_rvalid, 0);
    chk("rst_lk_err", lk_err, 0);
    chk("rst_lk_rdata", lk_rdata, '0);

    load_table(1'b0, 1'b0, HALF);
    run_table(1'b0);

    load_table(1'b0, 1'b1, HALF);
    sweep(1'b0);

    bn   = 8;
    binv = 1'b0;
    for (int j = 0; j < 8; j++) begin
      for (int l = 0; l < NL; l++) breq[j][l] = AW'((j * 97 + l * 211 + 5) % DEPTH);
      berr[j] = 1'b0;
    end
    burst("pipe8");

    load_table(1'b0, 1'b0, 100);
    load_table(1'b1, 1'b0, HALF);
    sweep(1'b1);
    run_table(1'b1);

    // Reset pulse shorter than a clock period, right after a lookup is accepted.
    lk_valid = 1'b1;
    lk_addr  = breq[0];
    @(negedge clk);
    lk_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_ld_ready", ld_ready, 0);
    chk("arst_lut_loaded", lut_loaded, 0);
    chk("arst_lk_ready", lk_ready, 0);
    chk("arst_lk_rvalid", lk_rvalid, 0);
    chk("arst_lk_err", lk_err, 0);
    chk("arst_lk_rdata", lk_rdata, '0);
    #1 rst = 1'b1;
    lk_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d rvalid", c), lk_rvalid, 0);
      chk($sformatf("post_rst%0d ld_ready", c), ld_ready, 0);
    end
    lk_valid   = 1'b0;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    chk("ld_ready_after_start", ld_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lut_bank.md
# lut_bank

Parametrised multi-direction lookup-table bank for the SR datapath. It holds one coefficient table replicated into `N_DIR` direction groups, each serving `N_RD` simultaneous lookups. The table is loaded through a two-word-per-cycle valid/ready stream with an internal address counter. It then serves pipelined lookups with a fixed 2-cycle latency. It sits between the coefficient loader and the SR interpolation stage.

## Interface
- `DATA_W`, 32: table word width.
- `ADDR_W`, 12: address width.
- `DEPTH`, 3392: table entries. Must be even and ≤ 2^ADDR_W.
- `N_DIR`, 4: direction groups (R, L, U, D = 0..3).
- `N_RD`, 4: read ports per direction. Must be even; each dual-port RAM serves 2.
- `clk`, in, 1: clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `load_start`, in, 1: pulse; begins or restarts a table load.
- `ld_valid`, in, 1: load beat valid.
- `ld_ready`, out, 1: load beat accepted when both `ld_valid` and `ld_ready` are high.
- `ld_data0`, in, DATA_W: entry at the even address.
- `ld_data1`, in, DATA_W: entry at the next (odd) address.
- `lut_loaded`, out, 1: table complete; lookups permitted.
- `lk_valid`, in, 1: lookup request.
- `lk_ready`, out, 1: equals `lut_loaded`.
- `lk_addr`, in, N_DIR·N_RD·ADDR_W: flattened addresses, index `d*N_RD+p`.
- `lk_rvalid`, out, 1: result valid.
- `lk_rdata`, out, N_DIR·N_RD·DATA_W: flattened results, same indexing as `lk_addr`.
- `lk_err`, out, 1: pulses with `lk_rvalid` when any address in that request was ≥ DEPTH.

## Operation
- **FSM `IDLE` → `LOAD`:** `load_start` clears the counter `wcnt` to 0 and clears `lut_loaded`.
- **`LOAD`:**
  - `ld_ready` = 1.
  - Each accepted beat is registered, then written next cycle: port A writes `ld_data0` at `wcnt`, port B writes `ld_data1` at `wcnt+1`.
  - The same write goes to every RAM in every direction.
  - `wcnt` += 2 per beat.
- **`LOAD` → `DONE`:** on the final write (`wcnt` = DEPTH−2). `lut_loaded` = 1 from the following cycle.
- **`DONE`:**
  - `ld_ready` = 0; `lk_ready` = 1.
  - `load_start` returns the FSM to `LOAD` and drops `lut_loaded`.
- **`load_start` in `LOAD`:** restarts at `wcnt` = 0. A beat accepted in the same cycle is discarded.
- **Lookups:**
  - Accepted only when `lk_valid` and `lk_ready` are both high; `lk_valid` while not loaded is ignored (no `rvalid`).
  - RAM pair k of direction d serves ports 2k (port A) and 2k+1 (port B).
- **Out-of-range address** (≥ DEPTH): that lane's `lk_rdata` = 0 and `lk_err` = 1. Other lanes are unaffected.
- **RAM enables:** asserted only on a write beat or an accepted lookup. `lk_rdata` holds its last value between results.

## Timing
- **Reset values:**
  - FSM = `IDLE`, `wcnt` = 0.
  - `ld_ready`, `lut_loaded`, `lk_ready`, `lk_rvalid`, `lk_err` = 0.
  - `lk_rdata` = 0.
  - RAM contents undefined.
- **Load:** beat accepted at edge n is written to the RAM at edge n+1.
- **Lookup:** request accepted at edge n has its addresses registered. The RAM is read at edge n+1. `lk_rvalid`, `lk_rdata` and `lk_err` are valid in the cycle after edge n+1, i.e. 2-cycle latency.
- **Throughput:** one lookup per cycle, fully pipelined. Back-to-back requests give back-to-back `rvalid`.
- **Reset mid-load or mid-lookup:** immediate return to `IDLE`. In-flight results are dropped; a reload is required.
- **`load_start` while a lookup is in flight:** the result still emerges 2 cycles after acceptance, with pre-reload data.

## Structure
- Package `lut_pkg`:
  - FSM state enum (`IDLE`, `LOAD`, `DONE`).
  - Lane-index helper `lane(d,p)`.
  - Default parameter constants.
- Sub-module `lut_dp_ram`:
  - Parametrised DATA_W/ADDR_W/DEPTH dual-port RAM; synchronous read and write, read latency 1.
  - Behavioural model, with a macro wrapper swapping in the foundry dual-port SRAM.
- Instances: N_DIR·N_RD/2 via generate.

## Test plan
- **Reset, then load ramp.** Load DEPTH/2 beats with `ld_data0`=2i and `ld_data1`=2i+1. Require `lut_loaded` exactly 1 cycle after the last write. Then look up addresses 0, 1, 3391 on all 16 lanes; require those values 2 cycles later.
- **Backpressure and gaps.** Drop `ld_valid` randomly during the load. Require `wcnt` advances only on accepted beats and the final contents are identical.
- **Pipelined lookups.** Issue 8 consecutive requests with distinct per-lane addresses. Require 8 consecutive `rvalid` cycles, in order, each matching its request.
- **Out-of-range lane.** Lane 5 addr = 3392, others valid. Require lane 5 = 0, `lk_err` = 1, and other lanes correct.
- **Restart.** `load_start` mid-load, then a full reload with inverted data. Require no old words survive and `lookup-before-loaded` yields no `rvalid`.
- **Async reset.** Assert `rst` low mid-lookup. Require all outputs 0 immediately, no stale `rvalid` after release, and `ld_ready` = 0 until the next `load_start`.
